// File: rtl/switch_debouncer.sv
// Push-button front end: per-channel two-flop synchroniser, consecutive-mismatch
// debounce counter, and registered press/release pulses aligned with the level.

module switch_debouncer_lane #(
  parameter int LIMIT = 250000,
  parameter int CW    = $clog2(LIMIT)
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Pressed,
  output logic o_Released
);

  localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          pressed_q, pressed_d;
  logic          released_q, released_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any edge that agrees with the stable level restarts the count, so the
  // counter can never run past CNT_MAX.
  always_comb begin
    stable_d   = stable_q;
    cnt_d      = '0;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d   = sync2_q;
        pressed_d  = sync2_q;
        released_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= 1'b0;
      cnt_q      <= '0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      sync1_q    <= i_Switch;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign o_Switch   = stable_q;
  assign o_Pressed  = pressed_q;
  assign o_Released = released_q;

endmodule

module switch_debouncer #(
  parameter int g_WIDTH          = 4,
  parameter int g_DEBOUNCE_LIMIT = 250000
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [g_WIDTH-1:0] i_Switches,
  output logic [g_WIDTH-1:0] o_Switches,
  output logic [g_WIDTH-1:0] o_Pressed,
  output logic [g_WIDTH-1:0] o_Released
);

  localparam int CW = (g_DEBOUNCE_LIMIT > 1) ? $clog2(g_DEBOUNCE_LIMIT) : 1;

  for (genvar g = 0; g < g_WIDTH; g++) begin : g_lane
    switch_debouncer_lane #(
      .LIMIT (g_DEBOUNCE_LIMIT),
      .CW    (CW)
    ) u_lane (
      .i_Clk      (i_Clk),
      .i_Reset    (i_Reset),
      .i_Switch   (i_Switches[g]),
      .o_Switch   (o_Switches[g]),
      .o_Pressed  (o_Pressed[g]),
      .o_Released (o_Released[g])
    );
  end

endmodule
